// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES definitions for the MixColumns engine: state and
//               column widths, FSM state encoding, the GF(2^8) xtime helper
//               and a byte-index macro for the byte-0-at-MSB state ordering.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef AES_PKG_BYTE_MSB
`define AES_PKG_BYTE_MSB
// MSB bit index of byte k in a 128-bit state where byte 0 sits at bits 127:120.
`define AES_BYTE_MSB(k) (127 - 8 * (k))
`endif

package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Multiply by x (0x02) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mix_column_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_column_word
// Description : Combinational MixColumns / InvMixColumns on one 32-bit column.
//               Row r of the column is byte col_in[31-8r -: 8].
// Ports       : col_in  [31:0] input column
//               dec            1 = InvMixColumns, 0 = MixColumns
//               col_out [31:0] transformed column
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  input  logic                 dec,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] a_in  [4];
  logic [7:0] a_pre [4];
  logic [7:0] u_w;
  logic [7:0] v_w;
  logic [7:0] t_w;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a_in[r] = col_in[31-8*r -: 8];
    end

    // The inverse matrix factors as forward matrix times a cheap
    // pre-conditioning step: fold 04*(a0^a2) into rows 0/2 and
    // 04*(a1^a3) into rows 1/3, then apply the forward transform.
    u_w = xtime(xtime(a_in[0] ^ a_in[2]));
    v_w = xtime(xtime(a_in[1] ^ a_in[3]));

    a_pre[0] = dec ? (a_in[0] ^ u_w) : a_in[0];
    a_pre[1] = dec ? (a_in[1] ^ v_w) : a_in[1];
    a_pre[2] = dec ? (a_in[2] ^ u_w) : a_in[2];
    a_pre[3] = dec ? (a_in[3] ^ v_w) : a_in[3];

    // out_r = 02*a_r ^ 03*a_{r+1} ^ a_{r+2} ^ a_{r+3}
    //       = a_r ^ t ^ 02*(a_r ^ a_{r+1}),  t = xor of all four rows.
    t_w = a_pre[0] ^ a_pre[1] ^ a_pre[2] ^ a_pre[3];

    col_out[31:24] = a_pre[0] ^ t_w ^ xtime(a_pre[0] ^ a_pre[1]);
    col_out[23:16] = a_pre[1] ^ t_w ^ xtime(a_pre[1] ^ a_pre[2]);
    col_out[15:8]  = a_pre[2] ^ t_w ^ xtime(a_pre[2] ^ a_pre[3]);
    col_out[7:0]   = a_pre[3] ^ t_w ^ xtime(a_pre[3] ^ a_pre[0]);
  end

endmodule

`default_nettype wire

// File: rtl/aes_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_columns_seq
// Description : Sequential MixColumns / InvMixColumns engine. Accepts one AES
//               state, transforms one column per cycle through a single
//               column unit, then presents the full result until taken.
// Ports       : clk, rst_n          clock, synchronous active-low reset
//               in_valid/in_ready  input handshake
//               in_state [127:0]   AES state, byte k at [127-8k -: 8]
//               in_dec             1 = inverse direction, latched on accept
//               out_valid/out_ready output handshake
//               out_state [127:0]  transformed state, same byte ordering
//               busy               block in flight (BUSY or DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_dec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  fsm_e                   fsm_q,     fsm_d;
  logic [1:0]             col_cnt_q, col_cnt_d;
  logic                   dec_q,     dec_d;
  logic [AES_STATE_W-1:0] state_q,   state_d;
  logic [AES_STATE_W-1:0] res_q,     res_d;

  logic [AES_COL_W-1:0]   col_in;
  logic [AES_COL_W-1:0]   col_out;

  // Single column unit shared across all columns of the block.
  aes_mix_column_word u_word (
    .col_in  (col_in),
    .dec     (dec_q),
    .col_out (col_out)
  );

  always_comb begin
    col_in = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_cnt_q == c[1:0]) begin
        col_in = state_q[`AES_BYTE_MSB(4*c) -: AES_COL_W];
      end
    end
  end

  // All outputs decode directly from the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q != ST_IDLE);
  assign out_state = res_q;

  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    dec_d     = dec_q;
    state_d   = state_q;
    res_d     = res_q;

    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = in_state;
          dec_d     = in_dec;
          col_cnt_d = 2'd0;
          fsm_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int c = 0; c < NCOL; c++) begin
          if (col_cnt_q == c[1:0]) begin
            res_d[`AES_BYTE_MSB(4*c) -: AES_COL_W] = col_out;
          end
        end
        if (col_cnt_q == 2'(NCOL - 1)) begin
          col_cnt_d = 2'd0;
          fsm_d     = ST_DONE;
        end else begin
          col_cnt_d = col_cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= ST_IDLE;
      col_cnt_q <= 2'd0;
      dec_q     <= 1'b0;
      state_q   <= '0;
      res_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      dec_q     <= dec_d;
      state_q   <= state_d;
      res_q     <= res_d;
    end
  end

endmodule

`default_nettype wire
